// File: rtl/reg_bank_sync.sv
// reg_bank_sync: clocked register bank with bypassed registered reads, compare steering and self-timed soft clear
module reg_bank_sync #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 3,
    parameter int OPC_W = 4,
    parameter logic [OPC_W-1:0] CMP_OPCODE = 4'b1001,
    parameter int ZERO_REG = 0
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              chip_enable,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] select1,
    input  logic [ADDR_W-1:0] select2,
    input  logic [ADDR_W-1:0] dest,
    input  logic [OPC_W-1:0]  opcode,
    input  logic              clear_req,
    output logic [DATA_W-1:0] source1,
    output logic [DATA_W-1:0] source2,
    output logic              rd_valid,
    output logic              busy
);
    localparam int DEPTH = 2 ** ADDR_W;

    typedef enum logic {IDLE, CLEAR} state_t;

    state_t            state, state_n;
    logic [ADDR_W-1:0] ptr, ptr_n;
    logic [DATA_W-1:0] mem [DEPTH];
    logic              wr_ok, rd_ok, wr_drop;
    logic [ADDR_W-1:0] addr2;
    logic [DATA_W-1:0] rv1, rv2;

    // accept qualifiers, port-2 steering and bypassed read values
    always_comb begin
        busy    = (state == CLEAR);
        wr_ok   = chip_enable & we & ~busy;
        rd_ok   = chip_enable & rd_en & ~busy;
        wr_drop = (ZERO_REG != 0) && (waddr == '0);
        addr2   = (opcode == CMP_OPCODE) ? dest : select2;
        rv1     = ((ZERO_REG != 0) && (select1 == '0)) ? '0 :
                  (wr_ok && waddr == select1) ? wdata : mem[select1];
        rv2     = ((ZERO_REG != 0) && (addr2 == '0)) ? '0 :
                  (wr_ok && waddr == addr2) ? wdata : mem[addr2];
    end

    // clear sequencer next state: one entry per cycle, ptr wraps back to 0 on exit
    always_comb begin
        state_n = state;
        ptr_n   = ptr;
        if (state == IDLE) begin
            if (chip_enable && clear_req) begin
                state_n = CLEAR;
                ptr_n   = '0;
            end
        end else begin
            ptr_n   = ptr + 1'b1;
            state_n = (&ptr) ? IDLE : CLEAR;
        end
    end

    // sequencer state and clear pointer
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
            ptr   <= '0;
        end else begin
            state <= state_n;
            ptr   <= ptr_n;
        end
    end

    // storage: clear sweep has priority, writes to a hardwired zero register are dropped
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (busy) begin
            mem[ptr] <= '0;
        end else if (wr_ok && !wr_drop) begin
            mem[waddr] <= wdata;
        end
    end

    // registered read ports: hold data when no read is accepted
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            source1  <= '0;
            source2  <= '0;
            rd_valid <= 1'b0;
        end else begin
            rd_valid <= rd_ok;
            if (rd_ok) begin
                source1 <= rv1;
                source2 <= rv2;
            end
        end
    end
endmodule

// File: tb/tb_reg_bank_sync.sv
// tb_reg_bank_sync: directed plus random checks of two bank variants against a behavioural model
module tb_reg_bank_sync;
    logic        clk = 0;
    logic        reset_n = 0;
    logic        chip_enable = 0, we = 0, rd_en = 0, clear_req = 0;
    logic [2:0]  waddr = 0, select1 = 0, select2 = 0, dest = 0;
    logic [15:0] wdata = 0;
    logic [3:0]  opcode = 0;
    logic [15:0] s1_a, s2_a, s1_b, s2_b;
    logic        v_a, v_b, busy_a, busy_b;

    logic [15:0] mm [2][8];
    logic [15:0] es1 [2];
    logic [15:0] es2 [2];
    logic        ev;
    int          clr_left;
    int          n_assert = 0;
    int          n_fail = 0;

    always #5 clk = ~clk;

    reg_bank_sync #(.ZERO_REG(0)) dut (
        .clk(clk), .reset_n(reset_n), .chip_enable(chip_enable), .we(we), .waddr(waddr),
        .wdata(wdata), .rd_en(rd_en), .select1(select1), .select2(select2), .dest(dest),
        .opcode(opcode), .clear_req(clear_req), .source1(s1_a), .source2(s2_a),
        .rd_valid(v_a), .busy(busy_a)
    );

    reg_bank_sync #(.ZERO_REG(1)) dut_z (
        .clk(clk), .reset_n(reset_n), .chip_enable(chip_enable), .we(we), .waddr(waddr),
        .wdata(wdata), .rd_en(rd_en), .select1(select1), .select2(select2), .dest(dest),
        .opcode(opcode), .clear_req(clear_req), .source1(s1_b), .source2(s2_b),
        .rd_valid(v_b), .busy(busy_b)
    );

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        chk("src1", s1_a, es1[0]);
        chk("src2", s2_a, es2[0]);
        chk("src1_z", s1_b, es1[1]);
        chk("src2_z", s2_b, es2[1]);
        chk("valid", 16'(v_a), 16'(ev));
        chk("valid_z", 16'(v_b), 16'(ev));
        chk("busy", 16'(busy_a), 16'(clr_left > 0));
        chk("busy_z", 16'(busy_b), 16'(clr_left > 0));
    endtask

    function automatic logic [15:0] model_rv(input int z, input logic [2:0] a, input logic wr,
                                             input logic [2:0] wa, input logic [15:0] wd);
        if (z == 1 && a == 0) return 16'h0;
        if (wr && wa == a) return wd;
        return mm[z][a];
    endfunction

    task automatic model_reset();
        for (int z = 0; z < 2; z++) begin
            for (int i = 0; i < 8; i++) mm[z][i] = 16'h0;
            es1[z] = 16'h0;
            es2[z] = 16'h0;
        end
        ev = 0;
        clr_left = 0;
    endtask

    task automatic step(input logic ce, input logic w, input logic r, input logic cr,
                        input logic [2:0] wa, input logic [15:0] wd, input logic [2:0] s1,
                        input logic [2:0] s2, input logic [2:0] d, input logic [3:0] op);
        logic bz, wr, rd;
        logic [2:0] a2;
        chip_enable = ce; we = w; rd_en = r; clear_req = cr;
        waddr = wa; wdata = wd; select1 = s1; select2 = s2; dest = d; opcode = op;
        bz = (clr_left > 0);
        wr = ce & w & ~bz;
        rd = ce & r & ~bz;
        a2 = (op == 4'b1001) ? d : s2;
        for (int z = 0; z < 2; z++) begin
            if (rd) begin
                es1[z] = model_rv(z, s1, wr, wa, wd);
                es2[z] = model_rv(z, a2, wr, wa, wd);
            end
            if (bz) mm[z][8 - clr_left] = 16'h0;
            else if (wr && !(z == 1 && wa == 0)) mm[z][wa] = wd;
        end
        ev = rd;
        if (bz) clr_left--;
        else if (ce && cr) clr_left = 8;
        @(posedge clk);
        #1;
        check_all();
    endtask

    task automatic do_reset();
        reset_n = 0;
        #1;
        model_reset();
        check_all();
        @(posedge clk);
        #1;
        reset_n = 1;
    endtask

    task automatic read_all();
        for (int i = 0; i < 8; i++) step(1, 0, 1, 0, 0, 0, 3'(i), 3'(7 - i), 0, 0);
    endtask

    initial begin
        model_reset();
        #2;
        do_reset();
        read_all();

        step(1, 1, 0, 0, 3, 16'hBEEF, 0, 0, 0, 0);
        step(1, 1, 0, 0, 5, 16'h1234, 0, 0, 0, 0);
        step(1, 0, 1, 0, 0, 0, 3, 5, 0, 0);

        step(1, 1, 0, 0, 2, 16'h00AA, 0, 0, 0, 0);
        step(1, 1, 0, 0, 6, 16'h5500, 0, 0, 0, 0);
        step(1, 0, 1, 0, 0, 0, 2, 4, 6, 4'b1001);

        step(1, 1, 1, 0, 1, 16'hCAFE, 1, 1, 0, 0);
        step(1, 1, 1, 0, 0, 16'hFFFF, 0, 0, 0, 0);
        step(1, 0, 1, 0, 0, 0, 0, 1, 0, 0);

        for (int i = 0; i < 8; i++) step(1, 1, 0, 0, 3'(i), 16'(16'h1111 * i), 0, 0, 0, 0);
        step(1, 0, 0, 1, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 8; i++) step(1, 1, 1, 1, 7, 16'h7777, 7, 6, 0, 0);
        read_all();

        step(1, 1, 0, 0, 4, 16'h4444, 0, 0, 0, 0);
        step(1, 0, 1, 0, 0, 0, 4, 4, 0, 0);
        step(0, 1, 1, 1, 4, 16'h9999, 0, 1, 0, 0);
        step(0, 1, 1, 1, 2, 16'h8888, 2, 4, 0, 0);
        step(1, 0, 1, 0, 0, 0, 4, 2, 0, 0);

        for (int i = 0; i < 8; i++) step(1, 1, 0, 0, 3'(i), 16'(16'hA000 + i), 0, 0, 0, 0);
        step(1, 0, 0, 1, 0, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        do_reset();
        read_all();

        for (int k = 0; k < 600; k++) begin
            step(($urandom_range(0, 9) != 0), 1'($urandom), 1'($urandom),
                 ($urandom_range(0, 39) == 0), 3'($urandom), 16'($urandom),
                 3'($urandom), 3'($urandom), 3'($urandom),
                 ($urandom_range(0, 2) == 0) ? 4'b1001 : 4'($urandom));
        end
        for (int i = 0; i < 10; i++) step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        read_all();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule

// File: doc/reg_bank_sync.md
Name: reg_bank_sync

Overview:
Parametrised, clocked successor to the combinational 8x16 register bank. Provides one synchronous write port and two registered read ports. Source 2 is steered to the destination register when the compare opcode is presented, so compare instructions can read rd. Adds write-to-read bypass, an optional hardwired zero register, and a self-timed soft-clear sequencer. Sits between the decode stage and the ALU operand latches.

Parameters:
DATA_W, 16, register data width in bits
ADDR_W, 3, register address width; DEPTH = 2**ADDR_W registers
OPC_W, 4, opcode width
CMP_OPCODE, 4'b1001, opcode value that steers read port 2 to dest
ZERO_REG, 0, 1 = register 0 always reads 0 and ignores writes

Ports:
clk  in  1  system clock, rising-edge active
reset_n  in  1  asynchronous active-low reset
chip_enable  in  1  qualifies we, rd_en and clear_req; 0 = bank idle
we  in  1  write request
waddr  in  ADDR_W  write address
wdata  in  DATA_W  write data
rd_en  in  1  read request
select1  in  ADDR_W  read port 1 address
select2  in  ADDR_W  read port 2 address (normal ops)
dest  in  ADDR_W  read port 2 address when opcode == CMP_OPCODE
opcode  in  OPC_W  current instruction opcode
clear_req  in  1  single-cycle request to zero all registers
source1  out  DATA_W  registered read data, port 1
source2  out  DATA_W  registered read data, port 2
rd_valid  out  1  source1/source2 updated by the read accepted on the previous edge
busy  out  1  clear sequence in progress

Behaviour:
- One clock domain. clk and reset_n are the only timing inputs.
- Reset (reset_n = 0, asynchronous): all DEPTH entries = 0; source1 = source2 = 0; rd_valid = 0; busy = 0; FSM = IDLE; clear pointer = 0. Reset asserted mid-clear aborts the sequence, and the bank is all zero.
- Accept conditions, evaluated at the rising edge:
  - wr_ok = chip_enable & we & ~busy
  - rd_ok = chip_enable & rd_en & ~busy
- Write: if wr_ok, mem[waddr] <= wdata. If ZERO_REG = 1 and waddr = 0, the write is dropped.
- Read address mux: addr2 = (opcode == CMP_OPCODE) ? dest : select2. addr1 = select1.
- Read value function rv(a):
  - 0 if ZERO_REG = 1 and a = 0
  - else wdata if wr_ok and waddr == a (same-cycle bypass)
  - else mem[a]
- Read: if rd_ok, source1 <= rv(addr1), source2 <= rv(addr2), rd_valid <= 1. Otherwise source1/source2 hold their value and rd_valid <= 0.
- Read latency is 1 cycle: data and rd_valid appear after the edge that accepted the read. Both ports may address the same register.
- chip_enable = 0: no write, no read, clear_req ignored. Outputs hold and rd_valid goes to 0. Outputs are never tri-stated.
- FSM:
  - IDLE: busy = 0. On an edge with chip_enable & clear_req -> CLEAR, ptr <= 0. A write/read accepted on that same edge still completes, including the read data.
  - CLEAR: busy = 1. Each edge: mem[ptr] <= 0, ptr <= ptr + 1. On the edge that clears ptr = DEPTH-1 -> IDLE, ptr <= 0.
  - Clear occupies exactly DEPTH cycles. busy rises the cycle after clear_req is accepted and falls after DEPTH cycles.
  - In CLEAR, clear_req and chip_enable are ignored; the sequence is self-timed.
- Width rules: all addresses are full ADDR_W, so no out-of-range access exists. ptr is ADDR_W bits and wraps naturally to 0 at the end of the sequence.

Test Plan:
- Reset/readback: assert reset_n = 0 mid-run, release. Read r0..r7 with rd_en = 1 -> every source = 0x0000; rd_valid goes high one cycle after each read.
- Write/read: write r3 = 0xBEEF, then r5 = 0x1234; read select1 = 3, select2 = 5, opcode = 0 -> next cycle source1 = 0xBEEF, source2 = 0x1234, rd_valid = 1.
- Compare steering: r2 = 0x00AA, r6 = 0x5500. Read select1 = 2, select2 = 4, dest = 6, opcode = 4'b1001 -> source2 = 0x5500 (not r4); source1 = 0x00AA.
- Bypass: in one cycle, write r1 = 0xCAFE and read select1 = select2 = 1 -> next cycle both sources = 0xCAFE. Repeat with ZERO_REG = 1, writing r0 = 0xFFFF -> both sources = 0x0000.
- Soft clear: fill r0..r7 with 0x1111*i, pulse clear_req -> busy high for exactly 8 cycles. Reads/writes during busy are ignored: rd_valid = 0 and a write to r7 is lost. After busy falls, all registers read 0.
- chip_enable/reset abort: with chip_enable = 0, drive we = 1, rd_en = 1, clear_req = 1 -> no state change, outputs held, rd_valid = 0. Start a clear, then assert reset_n = 0 at cycle 3 -> busy = 0 immediately and all registers = 0.
